// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg: shared constants and the {pc, inst} entry type for the fetch queue
package if_fetch_queue_pkg;
    localparam int          FQ_DEPTH    = 2;
    localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FQ_PC_STEP  = 32'd4;
    localparam logic [31:0] PC_ALIGN    = 32'hFFFF_FFFC;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: valid/ready handshake carrying fetched {pc, inst} toward decode
interface if_fetch_queue_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    modport master (output id_valid, id_pc, id_inst, input id_ready);
    modport slave (input id_valid, id_pc, id_inst, output id_ready);
endinterface

// File: rtl/if_fetch_queue_fifo.sv
// if_fetch_queue_fifo: DEPTH-entry {pc, inst} FIFO with push/pop and a clear that wins over both
module if_fetch_queue_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  fetch_entry_t               wr_data,
    output fetch_entry_t               rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    fetch_entry_t          mem_q [DEPTH];
    fetch_entry_t          mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    always_comb begin
        mem_d = mem_q;
        if (push && !clear) mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d = clear ? '0 : push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = clear ? '0 : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = clear           ? '0 :
                   push && !pop    ? count_q + (PW+1)'(1) :
                   pop && !push    ? count_q - (PW+1)'(1) : count_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: owns the PC, captures each {pc, rom_inst} into a small FIFO and hands it to decode
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = FQ_DEPTH,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC,
    parameter logic [31:0] PC_STEP  = FQ_PC_STEP
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    input  logic                   flush,
    output logic [31:0]            pc_addr,
    input  logic [31:0]            rom_inst,
    if_fetch_queue_if.master       id,
    output logic [$clog2(DEPTH):0] fq_count
);
    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [31:0]  pc_q, pc_d;
    logic         push, pop, clear;
    fetch_entry_t head, wr_entry;
    assign pc_addr     = pc_q;
    assign clear       = redirect_valid | flush;
    assign pop         = id.id_valid & id.id_ready & ~clear;
    // a full queue still accepts a new entry on the edge its head leaves
    assign push        = ~clear & ((fq_count < FULL) | (id.id_valid & id.id_ready));
    assign wr_entry    = '{pc: pc_q, inst: rom_inst};
    assign id.id_valid = fq_count != '0;
    assign id.id_pc    = id.id_valid ? head.pc : '0;
    assign id.id_inst  = id.id_valid ? head.inst : '0;
    always_comb begin
        pc_d = redirect_valid ? (redirect_pc & PC_ALIGN) : push ? pc_q + PC_STEP : pc_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end
    if_fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .clear   (clear),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (fq_count)
    );
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed spec scenarios plus random traffic checked against a queue-based model
module tb_if_fetch_queue;
    localparam int DEPTH = 2;
    logic        clk = 1'b0, rst_n = 1'b0, redirect_valid = 1'b0, flush = 1'b0;
    logic [31:0] redirect_pc = '0, pc_addr, rom_inst;
    logic [$clog2(DEPTH):0] fq_count;
    bit          rom_nop = 1'b1;
    int          checks = 0, failures = 0;
    logic [31:0] pc_m;
    logic [63:0] q [$];

    if_fetch_queue_if id_if();

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .pc_addr        (pc_addr),
        .rom_inst       (rom_inst),
        .id             (id_if),
        .fq_count       (fq_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    assign rom_inst = rom_nop ? 32'h0000_0013 : rom_hash(pc_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        check("pc_addr", 64'(pc_addr), 64'(pc_m));
        check("id_valid", 64'(id_if.id_valid), 64'(q.size() != 0));
        check("id_pc", 64'(id_if.id_pc), q.size() != 0 ? 64'(q[0][63:32]) : 64'd0);
        check("id_inst", 64'(id_if.id_inst), q.size() != 0 ? 64'(q[0][31:0]) : 64'd0);
        check("fq_count", 64'(fq_count), 64'(q.size()));
    endtask

    // compare, advance the model by one edge, then let the DUT take that edge
    task automatic step();
        bit pop, room;
        logic [31:0] inst;
        compare_all();
        pop = (q.size() != 0) && id_if.id_ready;
        if (redirect_valid) begin
            q.delete();
            pc_m = {redirect_pc[31:2], 2'b00};
        end else if (flush) begin
            q.delete();
        end else begin
            room = (q.size() < DEPTH) || pop;
            if (pop) void'(q.pop_front());
            if (room) begin
                inst = rom_nop ? 32'h0000_0013 : rom_hash(pc_m);
                q.push_back({pc_m, inst});
                pc_m = pc_m + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        flush = 1'b0;
        q.delete();
        pc_m = 32'h0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        id_if.id_ready = 1'b0;
        pc_m = 32'h0;
        #1;
        do_reset();
        check("reset_pc", 64'(pc_addr), 64'h0);
        check("reset_valid", 64'(id_if.id_valid), 64'h0);
        id_if.id_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        do_reset();
        id_if.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("full_count", 64'(fq_count), 64'd2);
        check("full_pc_hold", 64'(pc_addr), 64'h8);
        id_if.id_ready = 1'b1;
        check("drain0", 64'(id_if.id_pc), 64'h0);
        step();
        check("drain1", 64'(id_if.id_pc), 64'h4);
        step();
        check("drain2", 64'(id_if.id_pc), 64'h8);

        id_if.id_ready = 1'b0;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        check("redir_count", 64'(fq_count), 64'd0);
        check("redir_valid", 64'(id_if.id_valid), 64'd0);
        check("redir_pc", 64'(pc_addr), 64'h100);
        step();
        check("redir_id_pc", 64'(id_if.id_pc), 64'h100);

        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_001C;
        step();
        redirect_valid = 1'b0;
        step();
        check("pre_flush_pc", 64'(pc_addr), 64'h20);
        check("pre_flush_cnt", 64'(fq_count), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_pc", 64'(pc_addr), 64'h20);
        check("flush_cnt", 64'(fq_count), 64'd0);
        step();
        check("flush_id_pc", 64'(id_if.id_pc), 64'h20);

        id_if.id_ready = 1'b1;
        redirect_valid = 1'b1;
        flush = 1'b1;
        redirect_pc = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        flush = 1'b0;
        check("both_pc", 64'(pc_addr), 64'h40);
        check("both_cnt", 64'(fq_count), 64'd0);

        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap_pc0", 64'(pc_addr), 64'hFFFF_FFFC);
        step();
        check("wrap_pc1", 64'(pc_addr), 64'h0);
        check("wrap_id0", 64'(id_if.id_pc), 64'hFFFF_FFFC);
        step();
        check("wrap_id1", 64'(id_if.id_pc), 64'h0);

        id_if.id_ready = 1'b0;
        step();
        step();
        check("pre_arst_cnt", 64'(fq_count), 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_pc", 64'(pc_addr), 64'h0);
        check("arst_valid", 64'(id_if.id_valid), 64'h0);
        check("arst_cnt", 64'(fq_count), 64'h0);
        check("arst_id_pc", 64'(id_if.id_pc), 64'h0);
        check("arst_id_inst", 64'(id_if.id_inst), 64'h0);
        do_reset();
        check("post_arst_pc", 64'(pc_addr), 64'h0);

        rom_nop = 1'b0;
        for (int i = 0; i < 400; i++) begin
            id_if.id_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            step();
        end
        redirect_valid = 1'b0;
        flush = 1'b0;
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
